// File: rtl/fsub_pipe_if.sv
// Handshake bundle for fsub_pipe.
// Upstream: in_valid/in_ready with operands x1 (minuend) and x2 (subtrahend).
// Downstream: out_valid/out_ready with result y and overflow flag ovf.
// master: the side that drives operands and out_ready (operand select / writeback).
// slave:  the subtractor itself.
interface fsub_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] x1;
  logic [31:0] x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;

  modport master (
    output in_valid, x1, x2, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, x1, x2, out_ready,
    output in_ready, out_valid, y, ovf
  );
endinterface

// File: rtl/fsub_pipe.sv
// Three-stage pipelined binary32 subtractor, y = x1 - x2, round-to-nearest-even,
// subnormals kept, overflow flag for finite operands rounding to infinity.
// Ports:
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset
//   bus  - fsub_pipe_if.slave: in_valid/in_ready/x1/x2 in, out_valid/out_ready/y/ovf out
// Stages: S1 unpack/align/classify, S2 add/normalize, S3 round/pack into y/ovf.
// A stalled output freezes every stage; in_ready drops combinationally with it.
module fsub_pipe (
  input logic       clk,
  input logic       rst,
  fsub_pipe_if.slave bus
);

  logic        stall;
  logic        v1_q, v2_q, v3_q;
  logic [31:0] y_q;
  logic        ovf_q;

  // S1 combinational
  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [23:0] a_sig, b_sig;
  logic        swap;
  logic [7:0]  big_exp, sml_exp, exp_diff;
  logic [23:0] big_sig, sml_sig;
  logic [4:0]  shamt;
  logic [58:0] sml_wide;
  logic        a_inf, a_nan, b_inf, b_nan;

  logic        s1_sign_d, s1_sub_d, s1_sticky_d, s1_spec_d, s1_zsign_d;
  logic [7:0]  s1_exp_d;
  logic [26:0] s1_big_d, s1_sml_d;
  logic [31:0] s1_spec_y_d;

  logic        s1_sign_q, s1_sub_q, s1_sticky_q, s1_spec_q, s1_zsign_q;
  logic [7:0]  s1_exp_q;
  logic [26:0] s1_big_q, s1_sml_q;
  logic [31:0] s1_spec_y_q;

  // S2 combinational
  logic [26:0]       sml_jam;
  logic [27:0]       sum;
  logic [26:0]       v;
  logic [8:0]        ex;
  logic [4:0]        lz, lshift;
  logic signed [8:0] ep;
  logic [26:0]       s2_norm_d;
  logic [8:0]        s2_exp_d;

  logic [26:0] s2_norm_q;
  logic [8:0]  s2_exp_q;
  logic        s2_sign_q, s2_spec_q, s2_zsign_q;
  logic [31:0] s2_spec_y_q;

  // S3 combinational
  logic [23:0] sig;
  logic        rup;
  logic [24:0] sig25;
  logic [8:0]  er;
  logic [22:0] frac;
  logic [31:0] y_d;
  logic        ovf_d;

  assign stall         = v3_q & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v3_q;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;

  // ---------------------------------------------------------------- S1
  always_comb begin
    a_sign = bus.x1[31];
    b_sign = ~bus.x2[31];  // subtract as add of the negated subtrahend
    // Subnormals behave as exponent 1 with a zero hidden bit.
    a_exp  = (bus.x1[30:23] == 8'd0) ? 8'd1 : bus.x1[30:23];
    b_exp  = (bus.x2[30:23] == 8'd0) ? 8'd1 : bus.x2[30:23];
    a_sig  = {|bus.x1[30:23], bus.x1[22:0]};
    b_sig  = {|bus.x2[30:23], bus.x2[22:0]};

    swap     = {b_exp, b_sig} > {a_exp, a_sig};
    big_exp  = swap ? b_exp : a_exp;
    big_sig  = swap ? b_sig : a_sig;
    sml_exp  = swap ? a_exp : b_exp;
    sml_sig  = swap ? a_sig : b_sig;
    exp_diff = big_exp - sml_exp;
    shamt    = (exp_diff > 8'd31) ? 5'd31 : exp_diff[4:0];
    // Everything shifted below the 27-bit field collapses into sticky.
    sml_wide = {sml_sig, 3'b000, 32'd0} >> shamt;

    s1_sign_d   = swap ? b_sign : a_sign;
    s1_sub_d    = a_sign ^ b_sign;
    s1_exp_d    = big_exp;
    s1_big_d    = {big_sig, 3'b000};
    s1_sml_d    = sml_wide[58:32];
    s1_sticky_d = |sml_wide[31:0];
    s1_zsign_d  = bus.x1[31] & ~bus.x2[31];

    a_nan = (&bus.x1[30:23]) & (|bus.x1[22:0]);
    a_inf = (&bus.x1[30:23]) & ~(|bus.x1[22:0]);
    b_nan = (&bus.x2[30:23]) & (|bus.x2[22:0]);
    b_inf = (&bus.x2[30:23]) & ~(|bus.x2[22:0]);

    s1_spec_d   = (&bus.x1[30:23]) | (&bus.x2[30:23]);
    s1_spec_y_d = 32'd0;
    if (b_nan) begin
      s1_spec_y_d = {bus.x2[31], 8'hFF, 1'b1, bus.x2[21:0]};
    end else if (a_nan) begin
      s1_spec_y_d = {bus.x1[31], 8'hFF, 1'b1, bus.x1[21:0]};
    end else if (a_inf && b_inf) begin
      // inf - inf of like sign is invalid: canonical negative quiet NaN
      s1_spec_y_d = (bus.x1[31] != bus.x2[31]) ? {bus.x1[31], 8'hFF, 23'd0} : 32'hFFC0_0000;
    end else if (a_inf) begin
      s1_spec_y_d = bus.x1;
    end else if (b_inf) begin
      s1_spec_y_d = {~bus.x2[31], 8'hFF, 23'd0};
    end
  end

  // ---------------------------------------------------------------- S2
  always_comb begin
    // Jammed sticky takes part in the subtraction so borrows round correctly.
    sml_jam = {s1_sml_q[26:1], s1_sml_q[0] | s1_sticky_q};
    if (s1_sub_q) begin
      sum = {1'b0, s1_big_q} - {1'b0, sml_jam};
    end else begin
      sum = {1'b0, s1_big_q} + {1'b0, sml_jam};
    end

    if (sum[27]) begin
      v  = {sum[27:2], sum[1] | sum[0]};
      ex = {1'b0, s1_exp_q} + 9'd1;
    end else begin
      v  = sum[26:0];
      ex = {1'b0, s1_exp_q};
    end

    lz = 5'd26;
    for (int i = 0; i < 27; i++) begin
      if (v[i]) lz = 5'(26 - i);
    end

    ep = $signed(ex) - $signed({4'd0, lz});
    if (ep <= 9'sd0) begin
      // Stop normalizing at exponent 1; the result is subnormal.
      lshift   = ex[4:0] - 5'd1;
      s2_exp_d = 9'd0;
    end else begin
      lshift   = lz;
      s2_exp_d = $unsigned(ep);
    end
    s2_norm_d = v << lshift;
  end

  // ---------------------------------------------------------------- S3
  always_comb begin
    sig   = s2_norm_q[26:3];
    rup   = s2_norm_q[2] & (s2_norm_q[1] | s2_norm_q[0] | s2_norm_q[3]);
    sig25 = {1'b0, sig} + {24'd0, rup};

    if (sig25[24]) begin
      er   = s2_exp_q + 9'd1;
      frac = sig25[23:1];
    end else if ((s2_exp_q == 9'd0) && sig25[23]) begin
      er   = 9'd1;  // subnormal rounded up into the smallest normal
      frac = sig25[22:0];
    end else begin
      er   = s2_exp_q;
      frac = sig25[22:0];
    end

    y_d   = {s2_sign_q, er[7:0], frac};
    ovf_d = 1'b0;
    if (s2_spec_q) begin
      y_d = s2_spec_y_q;
    end else if (sig25 == 25'd0) begin
      y_d = {s2_zsign_q, 31'd0};
    end else if (er >= 9'd255) begin
      y_d   = {s2_sign_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end
  end

  // ---------------------------------------------------------------- state
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      v3_q  <= 1'b0;
      y_q   <= 32'd0;
      ovf_q <= 1'b0;
    end else if (!stall) begin
      v1_q <= bus.in_valid & bus.in_ready;
      v2_q <= v1_q;
      v3_q <= v2_q;
      // y/ovf keep their last value across bubbles.
      if (v2_q) begin
        y_q   <= y_d;
        ovf_q <= ovf_d;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      s1_sign_q   <= s1_sign_d;
      s1_sub_q    <= s1_sub_d;
      s1_exp_q    <= s1_exp_d;
      s1_big_q    <= s1_big_d;
      s1_sml_q    <= s1_sml_d;
      s1_sticky_q <= s1_sticky_d;
      s1_spec_q   <= s1_spec_d;
      s1_spec_y_q <= s1_spec_y_d;
      s1_zsign_q  <= s1_zsign_d;

      s2_norm_q   <= s2_norm_d;
      s2_exp_q    <= s2_exp_d;
      s2_sign_q   <= s1_sign_q;
      s2_spec_q   <= s1_spec_q;
      s2_spec_y_q <= s1_spec_y_q;
      s2_zsign_q  <= s1_zsign_q;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Self-checking bench for fsub_pipe: directed vectors, backpressure, mid-flight
// reset and a randomized stream scored against an exact-arithmetic reference.
module tb_fsub_pipe;

  logic clk;
  logic rst;
  int   checks;
  int   failures;
  int   delivered;
  logic prev_stall;
  logic [31:0] prev_y;
  logic [32:0] sb[$];  // expected {ovf, y} in issue order

  fsub_pipe_if bus ();

  fsub_pipe dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "timeout");
  end

  // Reference: every finite binary32 is an integer multiple of 2^-149, so the
  // exact difference is a wide integer that is then rounded once to binary32.
  function automatic logic [32:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
    logic [7:0]   ea, eb;
    logic [22:0]  fa, fb;
    logic [279:0] na, nb, mag, q, rem, half;
    logic         rs;
    int           p, k;
    ea = a[30:23]; fa = a[22:0];
    eb = b[30:23]; fb = b[22:0];
    if (eb == 8'hFF && fb != 0) return {1'b0, b[31], 8'hFF, 1'b1, fb[21:0]};
    if (ea == 8'hFF && fa != 0) return {1'b0, a[31], 8'hFF, 1'b1, fa[21:0]};
    if (ea == 8'hFF && eb == 8'hFF)
      return (a[31] != b[31]) ? {1'b0, a[31], 8'hFF, 23'd0} : {1'b0, 32'hFFC0_0000};
    if (ea == 8'hFF) return {1'b0, a};
    if (eb == 8'hFF) return {1'b0, ~b[31], 8'hFF, 23'd0};
    na = '0; na[23:0] = {ea != 8'd0, fa}; na = na << ((ea == 8'd0) ? 0 : int'(ea) - 1);
    nb = '0; nb[23:0] = {eb != 8'd0, fb}; nb = nb << ((eb == 8'd0) ? 0 : int'(eb) - 1);
    // a - b = a + (-b)
    if (a[31] == ~b[31]) begin
      mag = na + nb; rs = a[31];
    end else if (na >= nb) begin
      mag = na - nb; rs = a[31];
    end else begin
      mag = nb - na; rs = ~b[31];
    end
    if (mag == 0) return {1'b0, a[31] & ~b[31], 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    if (p <= 23) return {1'b0, rs, mag[30:0]};
    k    = p - 23;
    q    = mag >> k;
    rem  = mag - (q << k);
    half = 280'd1 << (k - 1);
    if (rem > half || (rem == half && q[0])) q = q + 1;
    if (q[24]) begin
      q = q >> 1;
      k = k + 1;
    end
    if (k + 1 >= 255) return {1'b1, rs, 8'hFF, 23'd0};
    return {1'b0, rs, 8'(k + 1), q[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] r;
    r = $urandom();
    case ($urandom_range(0, 7))
      0: r[30:23] = 8'd0;
      1: begin
        r[30:23] = 8'hFF;
        if ($urandom_range(0, 1) == 0) r[22:0] = 23'd0;
      end
      2: r[30:0] = 31'd0;
      3: r[30:23] = 8'($urandom_range(250, 254));
      default: r[30:23] = 8'($urandom_range(100, 154));
    endcase
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock of streaming traffic, scored against the queue.
  task automatic do_cycle(input logic iv, input logic [31:0] a, input logic [31:0] b,
                          input logic ordy, output logic took);
    logic [32:0] e;
    bus.in_valid  = iv;
    bus.x1        = a;
    bus.x2        = b;
    bus.out_ready = ordy;
    #2;
    if (prev_stall) begin
      chk("hold_y", bus.y, prev_y);
      chk("hold_valid", 32'(bus.out_valid), 32'd1);
    end
    if (bus.out_valid && !ordy) chk("ready_stall", 32'(bus.in_ready), 32'd0);
    else chk("ready_free", 32'(bus.in_ready), 32'd1);
    if (bus.out_valid && ordy) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL spurious_result: got y=%h expected no result", bus.y);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("stream_y", bus.y, e[31:0]);
        chk("stream_ovf", 32'(bus.ovf), 32'(e[32]));
        delivered++;
      end
    end
    took = iv && bus.in_ready;
    if (took) sb.push_back(ref_sub(a, b));
    prev_stall = bus.out_valid && !ordy;
    prev_y     = bus.y;
    @(posedge clk);
    #1;
  endtask

  // Single pair into an empty pipe: result must show after exactly 3 edges.
  task automatic directed(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ey, input logic eovf);
    bus.in_valid  = 1'b1;
    bus.x1        = a;
    bus.x2        = b;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk({tag, "_lat1"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_lat2"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    chk({tag, "_lat3"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_y"}, bus.y, ey);
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eovf));
    @(posedge clk);
    #1;
    chk({tag, "_drained"}, 32'(bus.out_valid), 32'd0);
    prev_stall = 1'b0;
  endtask

  initial begin
    logic        took;
    logic [31:0] a, b;
    int          bp_idx, stall_left, deliv_base;
    logic        seen, ordy;

    checks     = 0;
    failures   = 0;
    delivered  = 0;
    prev_stall = 1'b0;
    prev_y     = 32'd0;
    rst           = 1'b1;
    bus.in_valid  = 1'b1;  // ignored during reset
    bus.x1        = 32'h4040_0000;
    bus.x2        = 32'h3F80_0000;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", bus.y, 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("rst_no_ghost", 32'(bus.out_valid), 32'd0);

    directed("basic",     32'h4040_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    directed("cancel",    32'h3F80_0000, 32'h3F80_0000, 32'h0000_0000, 1'b0);
    directed("negzero",   32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 1'b0);
    directed("poszero",   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0);
    directed("tie_even",  32'h3F80_0000, 32'h3300_0000, 32'h3F80_0000, 1'b0);
    directed("subnormal", 32'h0080_0000, 32'h0000_0001, 32'h007F_FFFF, 1'b0);
    directed("overflow",  32'h7F7F_FFFF, 32'hFF7F_FFFF, 32'h7F80_0000, 1'b1);
    directed("inf_inf",   32'h7F80_0000, 32'h7F80_0000, 32'hFFC0_0000, 1'b0);
    directed("nan_x2",    32'h3F80_0000, 32'h7FC0_0001, 32'h7FC0_0001, 1'b0);

    // Backpressure: 5 back-to-back pairs, 3-cycle stall on the first result.
    bp_idx     = 0;
    seen       = 1'b0;
    stall_left = 0;
    deliv_base = delivered;
    for (int c = 0; c < 40; c++) begin
      if (bp_idx >= 5 && sb.size() == 0) break;
      ordy = 1'b1;
      if (bus.out_valid && !seen) begin
        seen       = 1'b1;
        stall_left = 3;
      end
      if (stall_left > 0) begin
        ordy = 1'b0;
        stall_left--;
      end
      a = {1'b0, 8'(127 + bp_idx), 23'(bp_idx * 32'h1357)};
      b = 32'h3F00_0000;
      do_cycle(bp_idx < 5, a, b, ordy, took);
      if (took) bp_idx++;
    end
    chk("bp_delivered", 32'(delivered - deliv_base), 32'd5);
    chk("bp_sb_empty", 32'(sb.size()), 32'd0);

    // Randomized stream with random backpressure.
    for (int c = 0; c < 800; c++) begin
      a = rand_op();
      case ($urandom_range(0, 3))
        0: b = rand_op();
        1: b = a ^ 32'($urandom_range(0, 255));
        2: b = {a[31:23], 23'($urandom())};
        default: b = {~a[31], a[30:0] ^ 31'($urandom_range(0, 15))};
      endcase
      do_cycle($urandom_range(0, 3) != 0, a, b, $urandom_range(0, 3) != 0, took);
    end
    for (int c = 0; c < 20; c++) begin
      if (sb.size() == 0) break;
      do_cycle(1'b0, 32'd0, 32'd0, 1'b1, took);
    end
    chk("rand_drained", 32'(sb.size()), 32'd0);

    // Reset with all three stages occupied.
    for (int c = 0; c < 3; c++) begin
      do_cycle(1'b1, 32'h4100_0000 + 32'(c), 32'h3F80_0000, 1'b1, took);
    end
    chk("mid_full", 32'(bus.out_valid), 32'd1);
    rst           = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    prev_stall = 1'b0;
    chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_y", bus.y, 32'd0);
    chk("mid_rst_ovf", 32'(bus.ovf), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk);
      #1;
      chk("mid_no_stale", 32'(bus.out_valid), 32'd0);
    end
    directed("after_rst", 32'hC0A0_0000, 32'h4000_0000, 32'hC0E0_0000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
